fetch_unit: RTL and testbench

Instruction-fetch stage that sits directly upstream of `instruction_memory`. It owns the program counter and drives the byte address into the memory's `pc` input. It samples the combinational `instruction_code` returned in the same cycle and registers it into an IF/ID pipeline latch for the decoder. It handles decode stalls, branch/jump redirects with wrong-path flush, and halts with a sticky fault on misaligned or out-of-range fetch addresses.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers the returned word into the IF/ID latch,
// and handles stalls, redirects with wrong-path flush, and sticky fetch faults.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = 109
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc,
  input  logic [31:0] instruction_code,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] fetch_count,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int unsigned XLEN = 32;
  // Highest PC whose full word still lies inside the memory; compared without a +3 overflow.
  localparam logic [XLEN-1:0] MAX_PC   = XLEN'(IMEM_BYTES - 4);
  localparam logic [XLEN-1:0] WORD_INC = XLEN'(4);

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic            if_valid_nxt;
  logic [XLEN-1:0] if_pc_nxt;
  logic [XLEN-1:0] if_instr_nxt;
  logic [XLEN-1:0] if_pc_plus4_nxt;
  logic [XLEN-1:0] fetch_count_nxt;
  logic            fault_nxt;
  logic [XLEN-1:0] fault_pc_nxt;

  // Next-state and next-register values; redirect outranks stall, stall outranks the range check.
  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    if_valid_nxt    = if_valid;
    if_pc_nxt       = if_pc;
    if_instr_nxt    = if_instr;
    if_pc_plus4_nxt = if_pc_plus4;
    fetch_count_nxt = fetch_count;
    fault_nxt       = fault;
    fault_pc_nxt    = fault_pc;

    case (state)
      RUN: begin
        if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
          state_nxt    = FAULT;
          fault_nxt    = 1'b1;
          fault_pc_nxt = redirect_target;
          if_valid_nxt = 1'b0;
        end else if (redirect_valid) begin
          pc_nxt       = redirect_target;
          if_valid_nxt = 1'b0;
        end else if (stall) begin
          pc_nxt = pc;
        end else if (pc > MAX_PC) begin
          state_nxt    = FAULT;
          fault_nxt    = 1'b1;
          fault_pc_nxt = pc;
          if_valid_nxt = 1'b0;
        end else begin
          if_instr_nxt    = instruction_code;
          if_pc_nxt       = pc;
          if_pc_plus4_nxt = pc + WORD_INC;
          if_valid_nxt    = 1'b1;
          pc_nxt          = pc + WORD_INC;
          fetch_count_nxt = fetch_count + XLEN'(1);
        end
      end
      FAULT: begin
        if_valid_nxt = 1'b0;
        fault_nxt    = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      pc          <= RESET_PC;
      if_valid    <= 1'b0;
      if_pc       <= '0;
      if_instr    <= '0;
      if_pc_plus4 <= WORD_INC;
      fetch_count <= '0;
      fault       <= 1'b0;
      fault_pc    <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_valid    <= if_valid_nxt;
      if_pc       <= if_pc_nxt;
      if_instr    <= if_instr_nxt;
      if_pc_plus4 <= if_pc_plus4_nxt;
      fetch_count <= fetch_count_nxt;
      fault       <= fault_nxt;
      fault_pc    <= fault_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized stall/redirect/reset traffic,
// checked against a word-level model of the fetch rules.
module tb_fetch_unit;

  localparam int unsigned IMEM_BYTES = 109;
  localparam int unsigned MEM_WORDS  = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instruction_code;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic [31:0] fetch_count;
  logic        fault;
  logic [31:0] fault_pc;

  logic [31:0] mem [0:MEM_WORDS-1];

  int tests  = 0;
  int failed = 0;

  // Model state: what the latch and counters should hold after each edge.
  logic [31:0] m_pc, m_if_pc, m_if_instr, m_count, m_fault_pc;
  logic        m_valid, m_fault;

  fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM_BYTES)) dut (
    .clk(clk), .reset(reset), .pc(pc), .instruction_code(instruction_code),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .if_pc_plus4(if_pc_plus4),
    .fetch_count(fetch_count), .fault(fault), .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a < 32'(MEM_WORDS * 4)) return mem[a[6:2]];
    return 32'h0000_0013;
  endfunction

  assign instruction_code = word_at(pc);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One edge of the intended behaviour, in priority order.
  task automatic model_edge(input logic rst, input logic s, input logic rv, input logic [31:0] rt);
    longint last_byte;
    if (rst) begin
      m_pc = 32'h0; m_valid = 1'b0; m_if_pc = 32'h0; m_if_instr = 32'h0;
      m_count = 32'h0; m_fault = 1'b0; m_fault_pc = 32'h0;
    end else if (m_fault) begin
      m_valid = 1'b0;
    end else if (rv && rt[1:0] != 2'b00) begin
      m_fault = 1'b1; m_fault_pc = rt; m_valid = 1'b0;
    end else if (rv) begin
      m_pc = rt; m_valid = 1'b0;
    end else if (!s) begin
      last_byte = longint'(m_pc) + 3;
      if (last_byte >= longint'(IMEM_BYTES)) begin
        m_fault = 1'b1; m_fault_pc = m_pc; m_valid = 1'b0;
      end else begin
        m_if_instr = word_at(m_pc);
        m_if_pc    = m_pc;
        m_valid    = 1'b1;
        m_pc       = m_pc + 32'd4;
        m_count    = m_count + 32'd1;
      end
    end
  endtask

  task automatic compare_all();
    chk("pc", pc, m_pc);
    chk("if_valid", 32'(if_valid), 32'(m_valid));
    chk("if_pc", if_pc, m_if_pc);
    chk("if_instr", if_instr, m_if_instr);
    chk("if_pc_plus4", if_pc_plus4, m_if_pc + 32'd4);
    chk("fetch_count", fetch_count, m_count);
    chk("fault", 32'(fault), 32'(m_fault));
    chk("fault_pc", fault_pc, m_fault_pc);
  endtask

  task automatic step(input logic rst, input logic s, input logic rv, input logic [31:0] rt);
    reset = rst; stall = s; redirect_valid = rv; redirect_target = rt;
    model_edge(rst, s, rv, rt);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [31:0] pc_before;
    logic        r_rst, r_stall, r_rv;
    logic [31:0] r_tgt;

    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = $urandom;
    mem[0]  = 32'h0094_0333;
    mem[2]  = 32'h0020_9133;
    mem[3]  = 32'h00c5_4ab3;
    mem[8]  = 32'h00a0_8513;
    mem[20] = 32'h0041_a463;

    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;

    // Reset held two cycles; nothing fetched yet.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    reset = 1'b0;
    chk("pre_pc", pc, 32'h0);
    chk("pre_valid", 32'(if_valid), 32'h0);

    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("first_valid", 32'(if_valid), 32'h1);
    chk("first_instr", if_instr, 32'h0094_0333);
    chk("first_plus4", if_pc_plus4, 32'h4);
    chk("first_pc", pc, 32'h4);
    chk("first_count", fetch_count, 32'h1);

    // Free run to if_pc = 32.
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0);
      if (if_pc == 32'd8) chk("run_instr8", if_instr, 32'h0020_9133);
    end
    chk("run_if_pc", if_pc, 32'd32);
    chk("run_instr32", if_instr, 32'h00a0_8513);
    chk("run_count", fetch_count, 32'd9);

    // Stall with pc = 12.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 32'h0);
    chk("stall_pc", pc, 32'd12);
    chk("stall_if_pc", if_pc, 32'd8);
    chk("stall_instr", if_instr, 32'h0020_9133);
    chk("stall_count", fetch_count, 32'd3);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("unstall_if_pc", if_pc, 32'd12);
    chk("unstall_instr", if_instr, 32'h00c5_4ab3);

    // Redirect beats stall, one bubble.
    step(1'b0, 1'b1, 1'b1, 32'h50);
    chk("redir_pc", pc, 32'h50);
    chk("redir_bubble", 32'(if_valid), 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("redir_if_pc", if_pc, 32'h50);
    chk("redir_instr", if_instr, 32'h0041_a463);

    // Misaligned redirect faults; later redirects ignored; reset recovers.
    pc_before = pc;
    step(1'b0, 1'b0, 1'b1, 32'h52);
    chk("mis_fault", 32'(fault), 32'h1);
    chk("mis_fault_pc", fault_pc, 32'h52);
    chk("mis_pc_held", pc, pc_before);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    chk("mis_ignored_pc", pc, pc_before);
    chk("mis_sticky", 32'(fault), 32'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("recover_fault", 32'(fault), 32'h0);
    chk("recover_if_pc", if_pc, 32'h0);

    // Last legal word, then out-of-range fetch.
    step(1'b0, 1'b0, 1'b1, 32'd104);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("edge_if_pc", if_pc, 32'd104);
    chk("edge_valid", 32'(if_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("oor_fault", 32'(fault), 32'h1);
    chk("oor_fault_pc", fault_pc, 32'd108);
    chk("oor_valid", 32'(if_valid), 32'h0);

    // Mid-run reset at pc = 20.
    step(1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    chk("mid_pc", pc, 32'd20);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_plus4", if_pc_plus4, 32'h4);
    chk("mid_rst_count", fetch_count, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      r_rst   = ($urandom_range(0, 99) < 4);
      r_stall = ($urandom_range(0, 99) < 30);
      r_rv    = ($urandom_range(0, 99) < 12);
      if ($urandom_range(0, 9) == 0) r_tgt = 32'($urandom_range(0, 130));
      else r_tgt = 32'($urandom_range(0, 31)) << 2;
      step(r_rst, r_stall, r_rv, r_tgt);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
